// File: rtl/float7_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : float7_sub_seq
//  Purpose  : Sequential subtractor c = a - b for the 7-bit unsigned float
//             format {e[2:0], m[3:0]}, value = 1.m x 2^(e-3) (hidden one,
//             bias 3, no zero encoding). Operands are aligned, subtracted
//             and then normalised one leading-zero per cycle by an FSM
//             sitting between valid/ready handshakes on both sides.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1  clock, rising edge
//    rst_n      in   1  asynchronous active-low reset
//    in_valid   in   1  operands a, b present
//    in_ready   out  1  block can accept operands (IDLE only)
//    a          in   7  minuend    {e, m}
//    b          in   7  subtrahend {e, m}
//    out_valid  out  1  c / underflow valid
//    out_ready  in   1  consumer takes the result
//    c          out  7  result {e, m}; zero whenever underflow is set
//    underflow  out  1  true result below 0.125 (includes a == b, b > a)
// ============================================================================
module float7_sub_seq #(
  parameter int GUARD = 2  // guard bits below the mantissa, must be >= 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] a,
  input  logic [6:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] c,
  output logic       underflow
);

  // Working mantissa: hidden one + 4 mantissa bits + guard bits.
  localparam int W = 5 + GUARD;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ALIGN = 3'd1;
  localparam logic [2:0] ST_SUB   = 3'd2;
  localparam logic [2:0] ST_NORM  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]   state_q, state_d;
  logic [6:0]   a_q, a_d;
  logic [6:0]   b_q, b_d;
  logic [W-1:0] ma_q, ma_d;
  logic [W-1:0] mb_q, mb_d;
  logic [W-1:0] mc_q, mc_d;
  logic [2:0]   ec_q, ec_d;
  logic         uf_q, uf_d;
  logic [6:0]   c_q, c_d;
  logic         underflow_q, underflow_d;

  // Decoded datapath conditions shared by next-state and datapath logic.
  logic         b_gt_a;
  logic         diff_zero;
  logic         norm_done;
  logic         norm_uf;
  logic [2:0]   exp_diff;
  logic [W-1:0] mb_ext;

  // The format is monotonic in its raw bit pattern, so an unsigned compare
  // of the packed words orders the values.
  assign b_gt_a    = (b_q > a_q);
  assign diff_zero = (ma_q == mb_q);
  assign norm_done = mc_q[W-1];
  assign norm_uf   = ~mc_q[W-1] && (ec_q == 3'd0);
  assign exp_diff  = a_q[6:4] - b_q[6:4];
  assign mb_ext    = {1'b1, b_q[3:0], {GUARD{1'b0}}};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        state_d = b_gt_a ? ST_DONE : ST_SUB;
      end
      ST_SUB: begin
        state_d = diff_zero ? ST_DONE : ST_NORM;
      end
      ST_NORM: begin
        if (norm_done || norm_uf) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    mc_d        = mc_q;
    ec_d        = ec_q;
    uf_d        = uf_q;
    c_d         = c_q;
    underflow_d = underflow_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d  = a;
          b_d  = b;
          uf_d = 1'b0;
        end
      end
      ST_ALIGN: begin
        if (b_gt_a) begin
          uf_d        = 1'b1;
          c_d         = 7'd0;
          underflow_d = 1'b1;
        end else begin
          ma_d = {1'b1, a_q[3:0], {GUARD{1'b0}}};
          // A 3-bit shift of at most 7 on a W>=6 bit word; bits shifted
          // out are simply lost (truncation toward zero).
          mb_d = mb_ext >> exp_diff;
          ec_d = a_q[6:4];
        end
      end
      ST_SUB: begin
        // b <= a was established in ALIGN, so this never wraps.
        mc_d = ma_q - mb_q;
        if (diff_zero) begin
          uf_d        = 1'b1;
          c_d         = 7'd0;
          underflow_d = 1'b1;
        end
      end
      ST_NORM: begin
        if (norm_done) begin
          c_d         = {ec_q, mc_q[W-2 -: 4]};
          underflow_d = 1'b0;
        end else if (norm_uf) begin
          uf_d        = 1'b1;
          c_d         = 7'd0;
          underflow_d = 1'b1;
        end else begin
          mc_d = {mc_q[W-2:0], 1'b0};
          ec_d = ec_q - 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= 7'd0;
      b_q         <= 7'd0;
      ma_q        <= '0;
      mb_q        <= '0;
      mc_q        <= '0;
      ec_q        <= 3'd0;
      uf_q        <= 1'b0;
      c_q         <= 7'd0;
      underflow_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      mc_q        <= mc_d;
      ec_q        <= ec_d;
      uf_q        <= uf_d;
      c_q         <= c_d;
      underflow_q <= underflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // c and underflow are only written on the way into DONE, so they stay
  // stable for as long as the consumer stalls.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    c         = c_q;
    underflow = underflow_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_float7_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_float7_sub_seq
//  Purpose  : Directed self-checking bench for float7_sub_seq with
//             hand-computed expected results, latency, back-pressure and
//             mid-operation reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_float7_sub_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] a;
  logic [6:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] c;
  logic       underflow;

  int n_vec;
  int n_err;

  float7_sub_seq #(.GUARD(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands at a falling edge; the following rising edge is the
  // acceptance edge T. Returns #1 after T.
  task automatic start_op(input logic [6:0] va, input logic [6:0] vb);
    @(negedge clk);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // lat = number of rising edges after T at which out_valid is first seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [6:0] va,
                        input logic [6:0] vb, input logic [6:0] exp_c,
                        input logic exp_uf, input int exp_lat);
    int lat;
    out_ready = 1'b1;
    start_op(va, vb);
    wait_valid(lat);
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq({tag, "_c"}, c, exp_c);
    check_eq({tag, "_uf"}, underflow, exp_uf);
    if (exp_lat >= 0) check_eq({tag, "_lat"}, lat, exp_lat);
    @(negedge clk);
    check_eq({tag, "_vdrop"}, out_valid, 0);
    check_eq({tag, "_rdy"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    int stray;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 7'd0;
    b         = 7'd0;

    // Reset state
    #12;
    check_eq("rst_rdy", in_ready, 1);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_c", c, 0);
    check_eq("rst_uf", underflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 12 - 3 = 9
    run_op("t1", 7'b1101000, 7'b1001000, 7'b1100010, 1'b0, 3);
    // 3 - 0.125 = 2.875 (alignment shift of 4)
    run_op("t2", 7'b1001000, 7'b0000000, 7'b1000111, 1'b0, 3);
    // 4.25 - 4 = 0.25, four normalisation shifts
    run_op("t3", 7'b1010001, 7'b1010000, 7'b0010000, 1'b0, 7);
    // 6 - 3.5 = 2.5, one normalisation shift
    run_op("t6m35", 7'b1011000, 7'b1001100, 7'b1000100, 1'b0, 4);
    // 16 - 0.125: shift of 7 drops b entirely, result truncates to 16
    run_op("dmax", 7'b1110000, 7'b0000000, 7'b1110000, 1'b0, 3);
    // 0.25 - 0.125 = 0.125: smallest representable, not underflow
    run_op("min", 7'b0010000, 7'b0000000, 7'b0000000, 1'b0, 4);
    // a == b
    run_op("eq", 7'b1101000, 7'b1101000, 7'b0000000, 1'b1, -1);
    // b > a
    run_op("bgt", 7'b1001000, 7'b1101000, 7'b0000000, 1'b1, -1);
    // 1.0625 - 1 = 0.0625 underflows
    run_op("uf0625", 7'b0110001, 7'b0110000, 7'b0000000, 1'b1, -1);
    // 0.2421875 - 0.125 = 0.1171875 underflows
    run_op("uflow2", 7'b0001111, 7'b0000000, 7'b0000000, 1'b1, -1);

    // Back-pressure: hold the result for 5 cycles, in_valid pulses ignored
    out_ready = 1'b0;
    start_op(7'b1101000, 7'b1001000);
    wait_valid(lat);
    check_eq("bp_first", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a        = 7'b0010000;
      b        = 7'b0000000;
      @(negedge clk);
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_c", c, 7'b1100010);
      check_eq("bp_uf", underflow, 0);
      check_eq("bp_rdy", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release", out_valid, 0);
    run_op("bp_next", 7'b1001000, 7'b0000000, 7'b1000111, 1'b0, 3);

    // Reset in the middle of NORM for the 4.25 - 4 case
    start_op(7'b1010001, 7'b1010000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_valid", out_valid, 0);
    check_eq("mrst_rdy", in_ready, 1);
    check_eq("mrst_c", c, 0);
    check_eq("mrst_uf", underflow, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check_eq("mrst_noresult", stray, 0);
    run_op("mrst_next", 7'b1010001, 7'b1010000, 7'b0010000, 1'b0, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
